// File: rtl/pci_arb_pkg.sv
// ---------------------------------------------------------------------------
// pci_arb_pkg
//   Shared definitions for the central PCI bus arbiter.
//   - arb_state_e       : arbiter FSM states
//   - DEF_START_TIMEOUT : default number of idle clocks a grantee may hold
//                         GNT_N without starting FRAME_N
// ---------------------------------------------------------------------------
package pci_arb_pkg;

   typedef enum logic [2:0] {
      ST_RESET,   // all grants released
      ST_PARK,    // bus parked on PARK_MASTER, nobody requesting
      ST_GRANT,   // winner granted, waiting for its FRAME_N
      ST_OWNED,   // grantee has started a transaction
      ST_SWITCH   // one all-high clock between two grants
   } arb_state_e;

   localparam int DEF_START_TIMEOUT = 16;

endpackage

// File: rtl/pci_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// pci_arb_rr_pick
//   Combinational round-robin picker. Scans REQ_N starting at the search
//   pointer and returns the first requesting master. With no requester the
//   winner is PARK_MASTER.
//   Ports:
//     i_req_n   [NUM_MASTERS-1:0] per-master request, active low
//     i_ptr     [IW-1:0]          search start index
//     o_winner  [IW-1:0]          selected master
//     o_any_req                   at least one master is requesting
// ---------------------------------------------------------------------------
module pci_arb_rr_pick #(
   parameter int NUM_MASTERS = 4,
   parameter int PARK_MASTER = 0,
   parameter int IW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] i_req_n,
   input  logic [IW-1:0]          i_ptr,
   output logic [IW-1:0]          o_winner,
   output logic                   o_any_req
);

   int w_idx;

   // Walk from the farthest candidate back to ptr so that the candidate
   // closest to ptr is the last one written and therefore wins.
   always_comb begin
      o_winner  = IW'(PARK_MASTER);
      o_any_req = 1'b0;
      w_idx     = 0;
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
         w_idx = int'(i_ptr) + i;
         if (w_idx >= NUM_MASTERS) w_idx = w_idx - NUM_MASTERS;
         if (!i_req_n[IW'(w_idx)]) begin
            o_winner  = IW'(w_idx);
            o_any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pci_bus_arbiter
//   Central PCI arbiter: round-robin REQ_N/GNT_N handshake with bus parking,
//   hidden arbitration during transactions and a start timeout for grantees
//   that never assert FRAME_N. Only FRAME_N/IRDY_N are observed.
//   Ports:
//     CLK        PCI clock, all state changes on posedge
//     RST_N      asynchronous reset, active HIGH (legacy name)
//     REQ_N      per-master request, active low
//     FRAME_N    bus FRAME_N (monitor only)
//     IRDY_N     bus IRDY_N (monitor only)
//     GNT_N      per-master grant, active low, at most one bit low
//     BUS_OWNER  master that started the current/last transaction
//     BUS_BUSY   transaction in progress
//     TIMEOUT    one-clock pulse when a grant is revoked for a missing start
// ---------------------------------------------------------------------------
module pci_bus_arbiter
   import pci_arb_pkg::*;
#(
   parameter int NUM_MASTERS   = 4,
   parameter int PARK_MASTER   = 0,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic [NUM_MASTERS-1:0]         REQ_N,
   input  logic                           FRAME_N,
   input  logic                           IRDY_N,
   output logic [NUM_MASTERS-1:0]         GNT_N,
   output logic [$clog2(NUM_MASTERS)-1:0] BUS_OWNER,
   output logic                           BUS_BUSY,
   output logic                           TIMEOUT
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam int CW = $clog2(START_TIMEOUT+1);
   localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS-1);
   localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT-1);

   arb_state_e             r_state;
   logic [NUM_MASTERS-1:0] r_gnt_n;
   logic [IW-1:0]          r_gnt_idx;   // current (or last) grantee
   logic [IW-1:0]          r_ptr;       // round-robin search start
   logic [CW-1:0]          r_cnt;       // idle clocks spent in GRANT
   logic                   r_prev_idle;
   logic                   r_busy;
   logic [IW-1:0]          r_owner;
   logic                   r_timeout;

   logic [IW-1:0]          w_winner;
   logic                   w_any_req;
   logic                   w_idle;
   logic                   w_start;
   logic [IW-1:0]          w_gnt_inc;

   function automatic logic [NUM_MASTERS-1:0] f_gnt(input logic [IW-1:0] idx);
      logic [NUM_MASTERS-1:0] v;
      v      = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   pci_arb_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .PARK_MASTER (PARK_MASTER),
      .IW          (IW)
   ) u_pick (
      .i_req_n   (REQ_N),
      .i_ptr     (r_ptr),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   assign w_idle    = FRAME_N & IRDY_N;
   assign w_gnt_inc = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
   // A start is FRAME_N falling after an idle sample while someone holds GNT.
   assign w_start   = r_prev_idle & ~FRAME_N &
                      (r_state inside {ST_PARK, ST_GRANT, ST_OWNED});

   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         r_state     <= ST_RESET;
         r_gnt_n     <= '1;
         r_gnt_idx   <= PARK_IDX;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_prev_idle <= 1'b1;
         r_busy      <= 1'b0;
         r_owner     <= PARK_IDX;
         r_timeout   <= 1'b0;
      end else begin
         r_prev_idle <= w_idle;
         r_timeout   <= 1'b0;
         r_cnt       <= '0;

         if (w_start) begin
            r_busy  <= 1'b1;
            r_owner <= r_gnt_idx;
         end else if (w_idle) begin
            r_busy  <= 1'b0;
         end

         case (r_state)
            ST_RESET: begin
               r_state   <= ST_PARK;
               r_gnt_idx <= PARK_IDX;
               r_gnt_n   <= f_gnt(PARK_IDX);
            end

            ST_PARK: begin
               if (w_start) begin
                  r_state <= ST_OWNED;
                  r_ptr   <= w_gnt_inc;
               end else if (w_any_req) begin
                  // Parked master asking for the bus already holds GNT.
                  if (w_winner == r_gnt_idx) begin
                     r_state <= ST_GRANT;
                  end else begin
                     r_state <= ST_SWITCH;
                     r_gnt_n <= '1;
                  end
               end
            end

            ST_GRANT: begin
               if (w_start) begin
                  r_state <= ST_OWNED;
                  r_ptr   <= w_gnt_inc;
               end else if (REQ_N[r_gnt_idx]) begin
                  // Grantee withdrew before starting. Handing GNT to another
                  // master always needs the all-high clock in between.
                  if (!w_any_req && r_gnt_idx == PARK_IDX) begin
                     r_state <= ST_PARK;
                  end else begin
                     r_state <= ST_SWITCH;
                     r_gnt_n <= '1;
                  end
               end else if (w_idle && r_gnt_idx != PARK_IDX) begin
                  // Requesting grantee is protected from preemption; only
                  // the start timeout can take the bus away.
                  if (r_cnt == TO_LAST) begin
                     r_timeout <= 1'b1;
                     r_ptr     <= w_gnt_inc;
                     r_state   <= ST_SWITCH;
                     r_gnt_n   <= '1;
                  end else begin
                     r_cnt     <= r_cnt + 1'b1;
                  end
               end
            end

            ST_OWNED: begin
               // Back-to-back start by the same grantee only moves ptr; the
               // new ptr is used for arbitration on the following edge.
               if (w_start) begin
                  r_ptr <= w_gnt_inc;
               end else if (w_winner != r_gnt_idx) begin
                  r_state <= ST_SWITCH;
                  r_gnt_n <= '1;
               end
            end

            ST_SWITCH: begin
               r_state   <= w_any_req ? ST_GRANT : ST_PARK;
               r_gnt_idx <= w_winner;
               r_gnt_n   <= f_gnt(w_winner);
            end

            default: begin
               r_state <= ST_RESET;
               r_gnt_n <= '1;
            end
         endcase
      end
   end

   assign GNT_N     = r_gnt_n;
   assign BUS_OWNER = r_owner;
   assign BUS_BUSY  = r_busy;
   assign TIMEOUT   = r_timeout;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_bus_arbiter
//   Directed scenarios for the PCI arbiter. Each scenario pushes the output
//   snapshots it expects, tagged with the clock count at which they must
//   appear. A monitor compares every change of the output tuple
//   {GNT_N, BUS_BUSY, BUS_OWNER, TIMEOUT} against the queue head.
// ---------------------------------------------------------------------------
module tb_pci_bus_arbiter;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [3:0] REQ_N;
   logic       FRAME_N;
   logic       IRDY_N;
   logic [3:0] GNT_N;
   logic [1:0] BUS_OWNER;
   logic       BUS_BUSY;
   logic       TIMEOUT;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         c;
      logic [3:0] g;
      logic       b;
      logic [1:0] o;
      logic       t;
   } exp_t;

   exp_t exp_q[$];

   pci_bus_arbiter #(
      .NUM_MASTERS   (4),
      .PARK_MASTER   (0),
      .START_TIMEOUT (16)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ_N     (REQ_N),
      .FRAME_N   (FRAME_N),
      .IRDY_N    (IRDY_N),
      .GNT_N     (GNT_N),
      .BUS_OWNER (BUS_OWNER),
      .BUS_BUSY  (BUS_BUSY),
      .TIMEOUT   (TIMEOUT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Expect snapshot k clocks after the current count.
   task automatic expect_at(input int k, input logic [3:0] g, input logic b,
                            input logic [1:0] o, input logic t);
      exp_t e;
      e = '{cyc + k, g, b, o, t};
      exp_q.push_back(e);
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge CLK);
   endtask

   // Monitor: every change of the output tuple is one comparison.
   initial begin
      logic [7:0] last;
      logic [7:0] cur;
      bit         first;
      exp_t       e;
      first = 1'b1;
      last  = '0;
      forever begin
         @(negedge CLK);
         cur = {GNT_N, BUS_BUSY, BUS_OWNER, TIMEOUT};
         if (first || cur !== last) begin
            first = 1'b0;
            last  = cur;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: at clk %0d got gnt=%b busy=%b owner=%0d to=%b, none expected",
                        cyc, GNT_N, BUS_BUSY, BUS_OWNER, TIMEOUT);
            end else begin
               e = exp_q.pop_front();
               if (e.c != cyc || e.g !== GNT_N || e.b !== BUS_BUSY ||
                   e.o !== BUS_OWNER || e.t !== TIMEOUT) begin
                  errors++;
                  $display("FAIL event: got clk %0d gnt=%b busy=%b owner=%0d to=%b, want clk %0d gnt=%b busy=%b owner=%0d to=%b",
                           cyc, GNT_N, BUS_BUSY, BUS_OWNER, TIMEOUT,
                           e.c, e.g, e.b, e.o, e.t);
               end
            end
         end
      end
   end

   initial begin
      RST_N   = 1'b1;
      REQ_N   = 4'b1111;
      FRAME_N = 1'b1;
      IRDY_N  = 1'b1;
      expect_at(1, 4'b1111, 1'b0, 2'd0, 1'b0);            // reset state
      step(3);

      // Release reset: parks on master 0 one clock later.
      RST_N = 1'b0;
      expect_at(1, 4'b1110, 1'b0, 2'd0, 1'b0);
      step(2);

      // Master 2 requests while parked: all-high clock, then grant.
      REQ_N = 4'b1011;
      expect_at(1, 4'b1111, 1'b0, 2'd0, 1'b0);
      expect_at(2, 4'b1011, 1'b0, 2'd0, 1'b0);
      step(2);
      // Master 2 starts and drops REQ_N on the same clock; grant returns to park.
      FRAME_N = 1'b0;
      REQ_N   = 4'b1111;
      expect_at(1, 4'b1011, 1'b1, 2'd2, 1'b0);
      expect_at(2, 4'b1111, 1'b1, 2'd2, 1'b0);
      expect_at(3, 4'b1110, 1'b0, 2'd2, 1'b0);
      step(1); FRAME_N = 1'b1; IRDY_N = 1'b0;
      step(1); IRDY_N  = 1'b1;
      step(2);

      // Masters 1 and 3 request continuously; ptr=3 after master 2.
      REQ_N = 4'b0101;
      expect_at(1, 4'b1111, 1'b0, 2'd2, 1'b0);
      expect_at(2, 4'b0111, 1'b0, 2'd2, 1'b0);
      step(2);
      FRAME_N = 1'b0;                                     // master 3 starts
      expect_at(1, 4'b0111, 1'b1, 2'd3, 1'b0);
      expect_at(2, 4'b1111, 1'b1, 2'd3, 1'b0);
      expect_at(3, 4'b1101, 1'b0, 2'd3, 1'b0);
      step(1); FRAME_N = 1'b1; IRDY_N = 1'b0;
      step(1); IRDY_N  = 1'b1;
      step(1);
      FRAME_N = 1'b0;                                     // master 1 starts
      expect_at(1, 4'b1101, 1'b1, 2'd1, 1'b0);
      expect_at(2, 4'b1111, 1'b1, 2'd1, 1'b0);
      expect_at(3, 4'b0111, 1'b0, 2'd1, 1'b0);
      step(1); FRAME_N = 1'b1; IRDY_N = 1'b0;
      step(1); IRDY_N  = 1'b1;
      step(1);

      // Master 3 granted but never starts: timeout after 16 idle clocks,
      // master 1 next; it also times out and master 3 follows.
      expect_at(16, 4'b1111, 1'b0, 2'd1, 1'b1);
      expect_at(17, 4'b1101, 1'b0, 2'd1, 1'b0);
      expect_at(33, 4'b1111, 1'b0, 2'd1, 1'b1);
      expect_at(34, 4'b0111, 1'b0, 2'd1, 1'b0);
      step(34);

      // Grantee withdraws with nobody else requesting: switch, then park.
      REQ_N = 4'b1111;
      expect_at(1, 4'b1111, 1'b0, 2'd1, 1'b0);
      expect_at(2, 4'b1110, 1'b0, 2'd1, 1'b0);
      step(3);

      // Hidden arbitration: master 0 requests during master 2's transaction.
      REQ_N = 4'b1011;
      expect_at(1, 4'b1111, 1'b0, 2'd1, 1'b0);
      expect_at(2, 4'b1011, 1'b0, 2'd1, 1'b0);
      step(2);
      FRAME_N = 1'b0;
      expect_at(1, 4'b1011, 1'b1, 2'd2, 1'b0);
      step(1);
      IRDY_N = 1'b0;
      REQ_N  = 4'b1110;
      expect_at(1, 4'b1111, 1'b1, 2'd2, 1'b0);
      expect_at(2, 4'b1110, 1'b1, 2'd2, 1'b0);
      step(3); FRAME_N = 1'b1;
      step(1); IRDY_N  = 1'b1;
      expect_at(1, 4'b1110, 1'b0, 2'd2, 1'b0);
      step(1); FRAME_N = 1'b0;                            // master 0 starts
      expect_at(1, 4'b1110, 1'b1, 2'd0, 1'b0);
      step(1); FRAME_N = 1'b1; IRDY_N = 1'b0; REQ_N = 4'b1111;
      step(1); IRDY_N  = 1'b1;
      expect_at(1, 4'b1110, 1'b0, 2'd0, 1'b0);
      step(2);

      // Reset in the middle of master 1's transaction.
      REQ_N = 4'b1101;
      expect_at(1, 4'b1111, 1'b0, 2'd0, 1'b0);
      expect_at(2, 4'b1101, 1'b0, 2'd0, 1'b0);
      step(2);
      FRAME_N = 1'b0;
      expect_at(1, 4'b1101, 1'b1, 2'd1, 1'b0);
      step(1);
      @(posedge CLK);
      #2;
      RST_N = 1'b1;                                       // between edges
      expect_at(0, 4'b1111, 1'b0, 2'd0, 1'b0);
      step(2);
      RST_N   = 1'b0;
      FRAME_N = 1'b1;
      REQ_N   = 4'b1111;
      expect_at(1, 4'b1110, 1'b0, 2'd0, 1'b0);
      step(4);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pci_bus_arbiter.md
# pci_bus_arbiter

Central PCI bus arbiter for the CPCI verification environment. It shares the single 32-bit PCI bus among up to `NUM_MASTERS` simulated or real initiators using a REQ_N/GNT_N handshake, round-robin priority, bus parking and the 16-clock start timeout. It sits beside the host/target models on the common bus. It observes FRAME_N/IRDY_N only and never drives AD, CBE or the control signals.

## Interface
- `NUM_MASTERS`, 4: number of REQ_N/GNT_N pairs (2..8).
- `PARK_MASTER`, 0: index granted when no master requests.
- `START_TIMEOUT`, 16: idle-bus clocks a grantee may hold GNT without starting FRAME_N.
- `CLK` input 1: PCI clock; all state changes on posedge.
- `RST_N` input 1: reset, asynchronous, active-high.
- `REQ_N` input NUM_MASTERS: per-master request, active low.
- `FRAME_N` input 1: bus FRAME_N, monitored.
- `IRDY_N` input 1: bus IRDY_N, monitored.
- `GNT_N` output NUM_MASTERS: per-master grant, active low, at most one bit low.
- `BUS_OWNER` output clog2(NUM_MASTERS): index of the master that started the current or last transaction.
- `BUS_BUSY` output 1: high while a transaction is in progress.
- `TIMEOUT` output 1: one-clock pulse when a grant is revoked for a missing start.

## Operation
- Bus idle means FRAME_N & IRDY_N, sampled at posedge. A transaction starts on the clock where the previous sample was idle, FRAME_N is now low, and a master g holds GNT. Set BUSY_OWNER←g and BUS_BUSY←1. BUS_BUSY clears on the first idle sample.
- Round robin: the search pointer `ptr` ←(g+1) mod NUM_MASTERS at each transaction start. The winner is the first master with REQ_N low scanning from `ptr`. If no master is requesting, the winner is PARK_MASTER.
- States:
  - `RESET`: all GNT_N=1.
  - `PARK`: GNT to PARK_MASTER, no requests.
  - `GRANT`: GNT to the winner, waiting for start.
  - `OWNED`: the grantee has started.
  - `SWITCH`: all GNT_N=1 for exactly one clock.
- Transitions:
  - RESET→PARK on the first clock after reset release.
  - PARK or GRANT: when the winner ≠ current grantee, go to SWITCH, then GRANT(winner) on the next clock.
  - GRANT→OWNED on transaction start by the grantee.
  - OWNED: hidden arbitration. If the winner ≠ grantee, go to SWITCH then GRANT. The transaction in flight continues; only the grant moves.
  - GRANT and the grantee raises REQ_N before starting: re-arbitrate via SWITCH, or to PARK if there are no requesters.
- Pre-start protection: while in GRANT, a requesting grantee is never preempted by other requesters, except through the timeout.
- Timeout:
  - A counter runs while in GRANT, the bus is idle and the grantee is not PARK_MASTER. It clears on any non-idle sample or on a state change.
  - At START_TIMEOUT, pulse TIMEOUT and set `ptr`←(grantee+1).
  - Then go to SWITCH and re-arbitrate. The timed-out master can win again only after the other requesters.
- Reset mid-transaction: GNT_N→all 1 immediately (asynchronous), state RESET, `ptr`=0, counters cleared, BUS_BUSY=0, BUS_OWNER=PARK_MASTER, TIMEOUT=0.

## Timing
- All outputs are registered. Reset values:
  - GNT_N all 1.
  - BUS_BUSY 0.
  - BUS_OWNER PARK_MASTER.
  - TIMEOUT 0.
- Request while parked on another master:
  - REQ_N low sampled at edge N.
  - GNT_N all 1 after N (SWITCH).
  - Winner GNT low after N+1.
  - Latency is 2 clocks.
- Request from PARK_MASTER while parked: already granted, 0 clocks.
- A grant never moves directly between masters without an all-high clock.
- Simultaneous REQ_N and start: the start is processed first, `ptr` is updated, and the winner is computed with the new `ptr` on the following edge.
- Pointer and index arithmetic is modulo NUM_MASTERS.
- Timeout counter width is clog2(START_TIMEOUT+1).

## Structure
- Shared package `pci_arb_pkg`: state enum (RESET, PARK, GRANT, OWNED, SWITCH) and the default START_TIMEOUT constant.
- One combinational sub-module, `pci_arb_rr_pick`: inputs REQ_N and `ptr`, outputs winner index and `any_req`.
- The FSM, counter and output registers live in the top module.

## Test plan
- Reset, no requests: GNT_N=4'b1110 one clock after RST_N falls to 0; BUS_BUSY=0.
- REQ_N=4'b1011 while parked: GNT_N goes 1110→1111→1011; master 2 starts FRAME_N → BUS_BUSY=1, BUS_OWNER=2.
- REQ_N=4'b0101 held continuously for several transactions: grants alternate 1→3→1, each preceded by an all-high clock.
- Master 1 granted but never asserts FRAME_N: after 16 idle clocks TIMEOUT pulses, GNT_N→1111, then grants master 3 if it is requesting, else PARK.
- During an OWNED transaction by master 2, master 0 requests: GNT_N=1111 then 1110 while FRAME_N stays low; BUS_OWNER stays 2 until master 0 starts.
- RST_N asserted mid-transaction: GNT_N=1111 and BUS_BUSY=0 immediately; PARK resumes one clock after release.
